// File: rtl/uart_fifo_device_pkg.sv
// Shared definitions for uart_fifo_device: register offsets, status/control
// bit layout and the TX/RX FSM state encodings.
package uart_fifo_device_pkg;

  localparam int unsigned DATA_W = 8;

  // Register offsets from ADDR_BASE
  localparam logic [7:0] REG_STATUS = 8'd0;
  localparam logic [7:0] REG_DATA   = 8'd1;
  localparam logic [7:0] REG_CTRL   = 8'd2;
  localparam logic [7:0] REG_COUNT  = 8'd3;

  // Control register bits
  localparam int unsigned CTRL_CLEAR = 0;
  localparam int unsigned CTRL_FLUSH = 1;

  // Status register layout; first member is bit 7
  typedef struct packed {
    logic zero;
    logic tx_overflow;
    logic frame_err;
    logic rx_overrun;
    logic rx_full;
    logic rx_avail;
    logic tx_full;
    logic tx_busy;
  } status_t;

  // Sticky error flags
  typedef struct packed {
    logic tx_overflow;
    logic frame_err;
    logic rx_overrun;
  } sticky_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_device_fifo.sv
// uart_sync_fifo: synchronous FIFO with push/pop/flush.
// Ports: clk, reset (sync, active high), push/wdata, pop -> rdata (registered
// on a successful pop), flush (empties the queue), full/empty (registered).
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  // Pop of an empty queue is ignored; push into a full queue needs a pop alongside
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next occupancy
  always_comb begin
    count_n = count;
    if (flush)
      count_n = '0;
    else if (do_push && !do_pop)
      count_n = count + CW'(1);
    else if (do_pop && !do_push)
      count_n = count - CW'(1);
  end

  // Pointers, occupancy, flags and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      rdata <= '0;
    end else begin
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
      // A pop coinciding with a flush still delivers the head
      if (do_pop)
        rdata <= mem[rptr];
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push)
          wptr <= wptr + AW'(1);
        if (do_pop)
          rptr <= rptr + AW'(1);
      end
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_device.sv
// uart_fifo_device: bus-mapped full-duplex 8N1 UART with TX/RX FIFOs.
// Ports: clk, reset (sync, active high); bus: enable, address, write, dbus_in,
// dbus_out (read data, one cycle after access); serial: tx (idle 1), rx (async).
module uart_fifo_device
  import uart_fifo_device_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  ADDR_BASE    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // Bus decode
  logic       enable_q;
  logic       acc;
  logic [7:0] off;
  logic       hit;
  logic       wr_data, rd_data, rd_status, wr_ctrl, rd_ctrl;

  assign acc       = enable & ~enable_q;
  assign off       = address - ADDR_BASE;
  assign hit       = acc & (off < REG_COUNT);
  assign wr_data   = hit &  write & (off == REG_DATA);
  assign rd_data   = hit & ~write & (off == REG_DATA);
  assign rd_status = hit & ~write & (off == REG_STATUS);
  assign wr_ctrl   = hit &  write & (off == REG_CTRL);
  assign rd_ctrl   = hit & ~write & (off == REG_CTRL);

  logic clr, flush;
  assign clr   = wr_ctrl & dbus_in[CTRL_CLEAR];
  assign flush = wr_ctrl & dbus_in[CTRL_FLUSH];

  // FIFOs
  logic             tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_rdata;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_rdata;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;

  assign rx_pop = rd_data & ~rx_empty;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (tx_pop),
    .flush (flush),
    .wdata (dbus_in),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .wdata (rx_sh),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX FSM
  tx_state_t         tx_state, tx_state_n;
  logic [CW-1:0]     tx_cnt, tx_cnt_n;
  logic [2:0]        tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic              tx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx       <= tx_n;
    end
  end

  // The popped byte lands in tx_rdata during START and is loaded at its end
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_n       = tx;
    tx_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == CELL_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_sh_n    = tx_rdata;
          tx_n       = tx_rdata[0];
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == CELL_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[DATA_W-1:1]};
            tx_n     = tx_sh[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == CELL_LAST) begin
          tx_cnt_n = '0;
          // Chain straight into the next frame when more data is queued
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_state_n = TX_START;
            tx_n       = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            tx_n       = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // RX synchroniser
  logic rx_m, rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // RX FSM
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic          frame_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // Start bit is confirmed half a cell in; every later sample is a full cell apart
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CELL_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[DATA_W-1:1]};
          if (rx_bit == 3'd7)
            rx_state_n = RX_STOP;
          else
            rx_bit_n = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CELL_LAST) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            frame_set  = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s)
          rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Status and sticky flags; a set in the same cycle as a clear wins
  sticky_t sticky, sticky_set;
  status_t status;

  always_comb begin
    sticky_set             = '0;
    sticky_set.tx_overflow = wr_data & tx_full & ~tx_pop;
    sticky_set.frame_err   = frame_set;
    sticky_set.rx_overrun  = rx_push & rx_full & ~rx_pop;
  end

  always_comb begin
    status             = '0;
    status.tx_busy     = (tx_state != TX_IDLE) | ~tx_empty;
    status.tx_full     = tx_full;
    status.rx_avail    = ~rx_empty;
    status.rx_full     = rx_full;
    status.rx_overrun  = sticky.rx_overrun;
    status.frame_err   = sticky.frame_err;
    status.tx_overflow = sticky.tx_overflow;
  end

  // Read path: a pop shows the FIFO's registered head the next cycle, then it is held
  logic [7:0] dbus_q;
  logic       rd_pop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      rd_pop_q <= 1'b0;
      dbus_q   <= '0;
      sticky   <= '0;
    end else begin
      enable_q <= enable;
      rd_pop_q <= rx_pop;
      sticky   <= sticky_t'((sticky & ~{3{clr}}) | sticky_set);
      if (rd_pop_q)
        dbus_q <= rx_rdata;
      if (rd_status)
        dbus_q <= status;
      else if (rd_ctrl || (rd_data && rx_empty))
        dbus_q <= '0;
    end
  end

  assign dbus_out = rd_pop_q ? rx_rdata : dbus_q;

endmodule
